pga_agc_controller: RTL and testbench
=====================================

Name: pga_agc_controller

Overview:
- Automatic gain control sequencer for the receiver front-end PGA.
- Measures peak absolute amplitude of the ADC sample stream over a fixed window and steps the PGA gain up or down.
- Drives the PGA SPI interface through a set/done handshake and holds off measurement while the analog chain settles.
- Supports a manual gain override from the host.

Parameters:
SAMPLE_W, 12, width of signed two's-complement ADC samples
WINDOW_LEN, 1024, valid samples per peak-measurement window (>=2)
SETTLE_CYCLES, 256, clk cycles ignored after each completed gain write (>=1)
HIGH_THRESH, 1536, peak strictly above this steps gain down
LOW_THRESH, 512, peak strictly below this steps gain up (LOW_THRESH < HIGH_THRESH)
GAIN_STEP, 4, gain code increment/decrement per decision
GAIN_MIN, 0, lowest permitted gain code
GAIN_MAX, 255, highest permitted gain code
INIT_GAIN, 128, gain written automatically after reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sample_i  in  SAMPLE_W  signed ADC sample
sample_valid_i  in  1  sample_i qualifier
enable_i  in  1  1 = automatic loop runs; 0 = loop frozen, manual loads still honoured
manual_gain_i  in  8  host gain code
manual_load_i  in  1  single-cycle request to write manual_gain_i
done_i  in  1  PGA interface transfer-complete pulse
gain_o  out  8  gain code presented to PGA interface
set_o  out  1  single-cycle write request to PGA interface
busy_o  out  1  high from set_o until done_i, inclusive
settled_o  out  1  high while in MEASURE (gain applied and settled)
peak_o  out  SAMPLE_W-1  last completed window peak (unsigned magnitude)

Behaviour:
- Reset values: state=WRITE, gain_o=INIT_GAIN, set_o=0, busy_o=0, settled_o=0, peak_o=0, pending manual flag=0, counters=0.
- States: WRITE, WAIT_DONE, SETTLE, MEASURE, DECIDE, IDLE.
- WRITE:
  - Assert set_o for exactly one cycle with gain_o already valid.
  - Next cycle: WAIT_DONE, busy_o=1.
  - First cycle after reset release is WRITE, so INIT_GAIN goes out automatically.
- WAIT_DONE:
  - gain_o must not change.
  - On done_i: busy_o=0 next cycle, settle counter cleared, go SETTLE.
  - done_i in any other state is ignored.
  - No timeout.
- SETTLE:
  - Count SETTLE_CYCLES clk cycles; samples ignored.
  - On terminal count: MEASURE if enable_i=1, else IDLE.
- MEASURE:
  - settled_o=1.
  - Per valid sample: mag = |sample_i|, with the most negative value saturating to 2^(SAMPLE_W-1)-1; running peak = max(peak, mag); sample count += 1.
  - When count reaches WINDOW_LEN (including the sample on that cycle): peak_o <= final peak, running peak and count clear, go DECIDE.
  - enable_i falling in MEASURE: discard partial window, go IDLE.
- DECIDE (one cycle):
  - peak_o > HIGH_THRESH: new = max(gain_o - GAIN_STEP, GAIN_MIN).
  - peak_o < LOW_THRESH: new = min(gain_o + GAIN_STEP, GAIN_MAX).
  - Otherwise new = gain_o.
  - Arithmetic is 9-bit unsigned with explicit clamp; no wrap-around.
  - If new != gain_o: gain_o <= new, go WRITE. Else go MEASURE, with no SPI write and no settle.
- IDLE: waits; enable_i=1 goes to MEASURE with a fresh window.
- Manual override:
  - manual_load_i in MEASURE, DECIDE, SETTLE or IDLE: next cycle gain_o <= manual_gain_i, go WRITE. Any partial window or settle count is discarded.
  - manual_load_i in WRITE or WAIT_DONE: latch value into the pending register and set the pending flag. On done_i, the pending value is loaded and the FSM goes WRITE instead of SETTLE.
  - A later manual_load_i overwrites a pending value.
  - Manual has priority over the DECIDE result in the same cycle.
  - A manual value outside [GAIN_MIN, GAIN_MAX] is clamped.
- Reset mid-transfer returns to the reset state; the INIT_GAIN write is reissued. Reset of the downstream SPI interface is its own concern.

Test Plan:
- Reset release, done_i returned 20 cycles after set_o -> one set_o pulse with gain_o=128; busy_o high exactly through the done cycle; settled_o rises 256 cycles after done.
- 1024 samples alternating +2000/-2000 -> peak_o=2000; gain 128->124 with one set_o. Repeat with constant 100 -> peak_o=100; gain 128->132.
- Samples at ±1000 -> peak_o=1000; no set_o; new window starts the cycle after DECIDE.
- Gain at 2, peak 2000 -> gain_o=0; at 0, high peak again -> no write. Gain at 253, low peak -> 255, then no further write.
- Sample -2048 within the window -> peak_o=2047.
- manual_load_i with 0x40 during WAIT_DONE -> after done_i, immediate second set_o with gain_o=0x40 and no settle in between. manual_load_i with 0x10 mid-MEASURE -> window aborted, set_o with 0x10.

Source files
------------

// File: rtl/pga_agc_controller.sv
`default_nettype none
// ============================================================================
// Module      : pga_agc_controller
// Description : AGC sequencer for the receiver PGA. Measures windowed peak ADC
//               magnitude, steps the gain, and writes it over a set/done link.
// Revision    : 1.0 - initial release
// ============================================================================
module pga_agc_controller #(
    parameter int SAMPLE_W      = 12,
    parameter int WINDOW_LEN    = 1024,
    parameter int SETTLE_CYCLES = 256,
    parameter int HIGH_THRESH   = 1536,
    parameter int LOW_THRESH    = 512,
    parameter int GAIN_STEP     = 4,
    parameter int GAIN_MIN      = 0,
    parameter int GAIN_MAX      = 255,
    parameter int INIT_GAIN     = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                sample_valid_i,
    input  logic                enable_i,
    input  logic [7:0]          manual_gain_i,
    input  logic                manual_load_i,
    input  logic                done_i,
    output logic [7:0]          gain_o,
    output logic                set_o,
    output logic                busy_o,
    output logic                settled_o,
    output logic [SAMPLE_W-2:0] peak_o
);

    localparam int c_PW     = SAMPLE_W - 1;
    localparam int c_WCNT_W = $clog2(WINDOW_LEN + 1);
    localparam int c_SCNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [c_WCNT_W-1:0] c_WIN_LAST = c_WCNT_W'(WINDOW_LEN - 1);
    localparam logic [c_SCNT_W-1:0] c_SET_LAST = c_SCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_PW-1:0]     c_MAG_MAX  = '1;
    localparam logic [c_PW-1:0]     c_HIGH     = c_PW'(HIGH_THRESH);
    localparam logic [c_PW-1:0]     c_LOW      = c_PW'(LOW_THRESH);
    localparam logic [9:0]          c_MIN10    = 10'(GAIN_MIN);
    localparam logic [9:0]          c_STEP10   = 10'(GAIN_STEP);
    localparam logic [8:0]          c_MAX9     = 9'(GAIN_MAX);
    localparam logic [8:0]          c_STEP9    = 9'(GAIN_STEP);
    localparam logic [7:0]          c_MIN8     = 8'(GAIN_MIN);
    localparam logic [7:0]          c_MAX8     = 8'(GAIN_MAX);
    localparam logic [7:0]          c_STEP8    = 8'(GAIN_STEP);
    localparam logic [7:0]          c_INIT8    = 8'(INIT_GAIN);

    typedef enum logic [2:0] {
        S_WRITE     = 3'd0,
        S_WAIT_DONE = 3'd1,
        S_SETTLE    = 3'd2,
        S_MEASURE   = 3'd3,
        S_DECIDE    = 3'd4,
        S_IDLE      = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_pend;
    logic [7:0]          r_pend_gain;
    logic [c_PW-1:0]     r_peak;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [c_SCNT_W-1:0] r_scnt;

    // Host gain codes are clamped into the legal range before use.
    function automatic logic [7:0] clamp_gain(input logic [7:0] g);
        logic [9:0] lo;
        lo = {2'b00, g} - c_MIN10;
        if (lo[9])
            return c_MIN8;
        else if ({1'b0, g} > c_MAX9)
            return c_MAX8;
        else
            return g;
    endfunction

    // Magnitude with the most negative code saturated to the largest positive.
    logic [SAMPLE_W-1:0] w_abs;
    logic [c_PW-1:0]     w_mag;
    logic [c_PW-1:0]     w_peak_nxt;
    assign w_abs      = sample_i[SAMPLE_W-1] ? (~sample_i + 1'b1) : sample_i;
    assign w_mag      = w_abs[SAMPLE_W-1] ? c_MAG_MAX : w_abs[c_PW-1:0];
    assign w_peak_nxt = (w_mag > r_peak) ? w_mag : r_peak;

    // Step arithmetic is done wide so the clamps see any over/underflow.
    logic [8:0] w_up;
    logic [9:0] w_dn_chk;
    logic [7:0] w_gain_up;
    logic [7:0] w_gain_dn;
    logic [7:0] w_gain_new;
    assign w_up       = {1'b0, gain_o} + c_STEP9;
    assign w_dn_chk   = {2'b00, gain_o} - c_STEP10 - c_MIN10;
    assign w_gain_up  = (w_up > c_MAX9) ? c_MAX8 : w_up[7:0];
    assign w_gain_dn  = w_dn_chk[9] ? c_MIN8 : (gain_o - c_STEP8);
    assign w_gain_new = (peak_o > c_HIGH) ? w_gain_dn :
                        (peak_o < c_LOW)  ? w_gain_up : gain_o;

    logic w_manual_now;
    assign w_manual_now = manual_load_i && (r_state != S_WRITE) && (r_state != S_WAIT_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_WRITE;
            gain_o      <= c_INIT8;
            set_o       <= 1'b0;
            busy_o      <= 1'b0;
            settled_o   <= 1'b0;
            peak_o      <= '0;
            r_pend      <= 1'b0;
            r_pend_gain <= '0;
            r_peak      <= '0;
            r_wcnt      <= '0;
            r_scnt      <= '0;
        end else begin
            set_o     <= 1'b0;
            settled_o <= 1'b0;
            if (w_manual_now) begin
                gain_o  <= clamp_gain(manual_gain_i);
                r_state <= S_WRITE;
                r_peak  <= '0;
                r_wcnt  <= '0;
                r_scnt  <= '0;
            end else begin
                case (r_state)
                    S_WRITE: begin
                        set_o   <= 1'b1;
                        busy_o  <= 1'b1;
                        r_state <= S_WAIT_DONE;
                        if (manual_load_i) begin
                            r_pend      <= 1'b1;
                            r_pend_gain <= manual_gain_i;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (done_i) begin
                            busy_o <= 1'b0;
                            r_scnt <= '0;
                            // A queued host value skips settling and is written at once.
                            if (r_pend || manual_load_i) begin
                                gain_o  <= clamp_gain(manual_load_i ? manual_gain_i : r_pend_gain);
                                r_pend  <= 1'b0;
                                r_state <= S_WRITE;
                            end else begin
                                r_state <= S_SETTLE;
                            end
                        end else if (manual_load_i) begin
                            r_pend      <= 1'b1;
                            r_pend_gain <= manual_gain_i;
                        end
                    end
                    S_SETTLE: begin
                        if (r_scnt == c_SET_LAST) begin
                            r_scnt <= '0;
                            if (enable_i) begin
                                r_state   <= S_MEASURE;
                                settled_o <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_scnt <= r_scnt + 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        if (!enable_i) begin
                            r_state <= S_IDLE;
                            r_peak  <= '0;
                            r_wcnt  <= '0;
                        end else begin
                            settled_o <= 1'b1;
                            if (sample_valid_i) begin
                                if (r_wcnt == c_WIN_LAST) begin
                                    peak_o    <= w_peak_nxt;
                                    r_peak    <= '0;
                                    r_wcnt    <= '0;
                                    r_state   <= S_DECIDE;
                                    settled_o <= 1'b0;
                                end else begin
                                    r_peak <= w_peak_nxt;
                                    r_wcnt <= r_wcnt + 1'b1;
                                end
                            end
                        end
                    end
                    S_DECIDE: begin
                        if (w_gain_new != gain_o) begin
                            gain_o  <= w_gain_new;
                            r_state <= S_WRITE;
                        end else begin
                            r_state   <= S_MEASURE;
                            settled_o <= 1'b1;
                        end
                    end
                    S_IDLE: begin
                        if (enable_i) begin
                            r_state   <= S_MEASURE;
                            settled_o <= 1'b1;
                        end
                    end
                    default: r_state <= S_WRITE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pga_agc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pga_agc_controller
// Description : Self-checking bench for pga_agc_controller with a PGA link model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pga_agc_controller;

    localparam int SW  = 12;
    localparam int WIN = 1024;
    localparam int SET = 256;

    localparam int K_ALT   = 0;
    localparam int K_CONST = 1;
    localparam int K_RAND  = 2;
    localparam int K_NEG   = 3;

    logic          clk;
    logic          rst;
    logic [SW-1:0] sample_i;
    logic          sample_valid_i;
    logic          enable_i;
    logic [7:0]    manual_gain_i;
    logic          manual_load_i;
    logic          done_i;
    logic [7:0]    gain_o;
    logic          set_o;
    logic          busy_o;
    logic          settled_o;
    logic [SW-2:0] peak_o;

    pga_agc_controller dut (
        .clk            (clk),
        .rst            (rst),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .enable_i       (enable_i),
        .manual_gain_i  (manual_gain_i),
        .manual_load_i  (manual_load_i),
        .done_i         (done_i),
        .gain_o         (gain_o),
        .set_o          (set_o),
        .busy_o         (busy_o),
        .settled_o      (settled_o),
        .peak_o         (peak_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_set    = 0;
    int last_gain = -1;
    int done_cyc = 0;
    int done_lat = 20;
    int mgain    = 128;

    typedef struct {
        int preset;
        int kind;
        int amp;
        int exp_peak;
        int exp_gain;
    } vec_t;
    vec_t vecs[12];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int mag(input int s);
        int m;
        m = (s < 0) ? -s : s;
        return (m > 2047) ? 2047 : m;
    endfunction

    function automatic int next_gain(input int g, input int pk);
        if (pk > 1536) return (g - 4 < 0) ? 0 : g - 4;
        if (pk < 512)  return (g + 4 > 255) ? 255 : g + 4;
        return g;
    endfunction

    // PGA link model: answers each write with done after done_lat cycles.
    initial begin
        int cnt;
        bit prev_set;
        bit chk_low;
        cnt = 0; prev_set = 0; chk_low = 0;
        done_i = 1'b0;
        forever begin
            @(negedge clk);
            done_i = 1'b0;
            if (chk_low) begin
                check("busy_after_done", int'(busy_o), 0);
                chk_low = 0;
            end
            if (rst) begin
                cnt = 0;
            end else if (set_o) begin
                check("set_single_cycle", int'(prev_set), 0);
                check("busy_at_set", int'(busy_o), 1);
                n_set++;
                last_gain = int'(gain_o);
                cnt = done_lat;
            end else if (cnt > 0) begin
                check("gain_stable_busy", int'(gain_o), last_gain);
                check("busy_during_xfer", int'(busy_o), 1);
                cnt--;
                if (cnt == 0) begin
                    done_i   = 1'b1;
                    done_cyc = cyc;
                    chk_low  = 1;
                end
            end
            prev_set = set_o;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic wait_set(input int target, input int budget);
        for (int i = 0; i < budget && n_set < target; i++) @(negedge clk);
        check("set_seen", n_set, target);
    endtask

    // Junk samples are driven while waiting; they must be ignored outside MEASURE.
    task automatic wait_settled(input int budget, output int at);
        int r;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (settled_o) begin
                at = cyc;
                break;
            end
            r = int'($urandom_range(4095));
            sample_i = r[SW-1:0];
            sample_valid_i = 1'b1;
        end
        sample_valid_i = 1'b0;
        check("settled_reached", int'(settled_o), 1);
    endtask

    task automatic pulse_manual(input int v);
        @(negedge clk);
        manual_gain_i = v[7:0];
        manual_load_i = 1'b1;
        @(negedge clk);
        manual_load_i = 1'b0;
    endtask

    task automatic manual_set(input int v);
        int n0, at;
        n0 = n_set;
        pulse_manual(v);
        wait_set(n0 + 1, 10);
        check("manual_set_gain", last_gain, v);
        wait_settled(done_lat + SET + 50, at);
        mgain = v;
    endtask

    task automatic send_samples(input int kind, input int amp, input int n, output int mpeak);
        int s;
        mpeak = 0;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(3) == 0) begin
                @(negedge clk);
                sample_valid_i = 1'b0;
            end
            @(negedge clk);
            case (kind)
                K_ALT:   s = (i % 2 == 1) ? -amp : amp;
                K_CONST: s = amp;
                K_RAND:  s = (i == n / 2) ? (($urandom_range(1) == 1) ? amp : -amp)
                                          : int'($urandom_range(2 * amp)) - amp;
                default: s = (i == n / 3) ? -2048 : int'($urandom_range(2 * amp)) - amp;
            endcase
            sample_i = s[SW-1:0];
            sample_valid_i = 1'b1;
            if (mag(s) > mpeak) mpeak = mag(s);
        end
        @(negedge clk);
        sample_valid_i = 1'b0;
    endtask

    // Called one cycle after the last sample of a window (DUT in DECIDE).
    task automatic finish_window(input int exp_peak, input int exp_gain);
        int n0, at;
        n0 = n_set;
        check("peak", int'(peak_o), exp_peak);
        check("settled_in_decide", int'(settled_o), 0);
        @(negedge clk);
        if (exp_gain != mgain) begin
            check("gain_updated", int'(gain_o), exp_gain);
            wait_set(n0 + 1, 10);
            check("written_gain", last_gain, exp_gain);
            wait_settled(done_lat + SET + 50, at);
        end else begin
            check("no_write_measure", int'(settled_o), 1);
            check("gain_held", int'(gain_o), exp_gain);
            repeat (3) @(negedge clk);
            check("no_set", n_set, n0);
        end
        mgain = exp_gain;
    endtask

    initial begin
        int at, mp, n0, g, amp;

        vecs[0]  = '{-1,  K_ALT,   2000, 2000, 124};
        vecs[1]  = '{128, K_CONST, 100,  100,  132};
        vecs[2]  = '{-1,  K_ALT,   1000, 1000, 132};
        vecs[3]  = '{2,   K_ALT,   2000, 2000, 0};
        vecs[4]  = '{-1,  K_CONST, 1900, 1900, 0};
        vecs[5]  = '{253, K_CONST, 50,   50,   255};
        vecs[6]  = '{-1,  K_CONST, 0,    0,    255};
        vecs[7]  = '{128, K_NEG,   300,  2047, 124};
        vecs[8]  = '{-1,  K_CONST, 1536, 1536, 124};
        vecs[9]  = '{-1,  K_ALT,   512,  512,  124};
        vecs[10] = '{-1,  K_CONST, 1537, 1537, 120};
        vecs[11] = '{-1,  K_ALT,   511,  511,  124};

        rst = 1'b1;
        sample_i = '0;
        sample_valid_i = 1'b0;
        enable_i = 1'b1;
        manual_gain_i = '0;
        manual_load_i = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_gain", int'(gain_o), 128);
        check("rst_set", int'(set_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_settled", int'(settled_o), 0);
        check("rst_peak", int'(peak_o), 0);

        rst = 1'b0;
        wait_set(1, 10);
        check("init_write_gain", last_gain, 128);
        wait_settled(done_lat + SET + 50, at);
        check("settle_latency", at - done_cyc, SET + 1);
        mgain = 128;

        for (int v = 0; v < 12; v++) begin
            if (vecs[v].preset >= 0) manual_set(vecs[v].preset);
            send_samples(vecs[v].kind, vecs[v].amp, WIN, mp);
            finish_window(vecs[v].exp_peak, vecs[v].exp_gain);
        end

        // Host load during a transfer is queued and written right after done.
        n0 = n_set;
        pulse_manual(8'h20);
        wait_set(n0 + 1, 10);
        repeat (3) @(negedge clk);
        pulse_manual(8'h40);
        wait_set(n0 + 2, done_lat + 10);
        check("pending_gain", last_gain, 8'h40);
        check("pending_no_settle", int'(settled_o), 0);
        wait_settled(done_lat + SET + 50, at);
        mgain = 8'h40;

        // Host load mid-window aborts the window.
        send_samples(K_ALT, 2000, 500, mp);
        n0 = n_set;
        pulse_manual(8'h10);
        wait_set(n0 + 1, 10);
        check("abort_gain", last_gain, 8'h10);
        wait_settled(done_lat + SET + 50, at);
        mgain = 8'h10;
        send_samples(K_CONST, 100, WIN, mp);
        finish_window(100, 8'h14);

        // Disabling mid-window discards it; re-enable starts a fresh one.
        send_samples(K_ALT, 2000, 400, mp);
        enable_i = 1'b0;
        n0 = n_set;
        @(negedge clk);
        check("idle_not_settled", int'(settled_o), 0);
        repeat (5) @(negedge clk);
        check("idle_no_set", n_set, n0);
        enable_i = 1'b1;
        @(negedge clk);
        check("reenable_measure", int'(settled_o), 1);
        send_samples(K_CONST, 100, WIN, mp);
        finish_window(100, next_gain(mgain, 100));

        // Reset during a transfer reissues the initial write.
        n0 = n_set;
        pulse_manual(8'h33);
        wait_set(n0 + 1, 10);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_gain", int'(gain_o), 128);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_settled", int'(settled_o), 0);
        check("midrst_peak", int'(peak_o), 0);
        rst = 1'b0;
        n0 = n_set;
        wait_set(n0 + 1, 10);
        check("midrst_rewrite", last_gain, 128);
        wait_settled(done_lat + SET + 50, at);
        mgain = 128;

        // Randomized windows checked against the reference rules.
        for (int r = 0; r < 6; r++) begin
            done_lat = int'($urandom_range(30, 1));
            if ($urandom_range(2) == 0) begin
                g = int'($urandom_range(255));
                manual_set(g);
            end
            amp = int'($urandom_range(2047));
            send_samples(K_RAND, amp, WIN, mp);
            finish_window(mp, next_gain(mgain, mp));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
